hart_boot_sequencer: RTL and testbench



---
 rtl/hart_boot_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_hart_boot_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hart_boot_sequencer.sv
// Reset/boot sequencer for an N-hart cluster: hold, staggered release, run, and WFI resync.
// Optional resync sleep-wait timeout with debug kick enabled by HART_BOOT_SEQ_TIMEOUT_EN.
module hart_boot_sequencer #(
  parameter int unsigned NHARTS         = 3,
  parameter logic [31:0] BASE_BOOT_ADDR = 32'h0001_0000,
  parameter logic [31:0] WFI_BOOT_ADDR  = BASE_BOOT_ADDR + 32'h200,
  parameter int unsigned RST_HOLD       = 4,
  parameter int unsigned STAGGER        = 2,
  parameter int unsigned TIMEOUT        = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   mode_i,
  input  logic [NHARTS-1:0]      hart_en_i,
  input  logic                   resync_i,
  input  logic [NHARTS-1:0]      sleep_i,
  output logic [NHARTS-1:0]      core_rst_no,
  output logic [NHARTS-1:0][31:0] boot_addr_o,
  output logic [NHARTS-1:0]      debug_req_o,
  output logic [NHARTS-1:0]      hart_ready_o,
  output logic                   busy_o,
  output logic                   all_sleep_o,
  output logic                   timeout_o
);

  localparam int unsigned PW   = (NHARTS > 1) ? $clog2(NHARTS) : 1;
  localparam int unsigned CMAX = (RST_HOLD > STAGGER) ? RST_HOLD : STAGGER;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ASSERT, S_RELEASE, S_RUN, S_SYNC
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [NHARTS-1:0] en_q, en_d;
  logic [NHARTS-1:0] sel_q, sel_d;
  logic [NHARTS-1:0] rst_no_q, rst_no_d;
  logic              all_sleep_q, all_sleep_d;

  logic              all_sleep_now;
  logic [PW-1:0]     first_idx, nxt_idx;
  logic              has_nxt;

`ifdef HART_BOOT_SEQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              timeout_q, timeout_d;
  logic [NHARTS-1:0] dbg_q, dbg_d;
`endif

  assign all_sleep_now = (en_q != '0) && ((sleep_i & en_q) == en_q);

  // Lowest enabled hart, and the next enabled hart above ptr_q.
  always_comb begin
    first_idx = '0;
    nxt_idx   = '0;
    has_nxt   = 1'b0;
    for (int i = NHARTS - 1; i >= 0; i--) begin
      if (en_q[i]) begin
        first_idx = PW'(i);
        if (i > int'(ptr_q)) begin
          nxt_idx = PW'(i);
          has_nxt = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    en_d        = en_q;
    sel_d       = sel_q;
    rst_no_d    = rst_no_q;
    all_sleep_d = ((state_q == S_RUN) || (state_q == S_SYNC)) && all_sleep_now;
`ifdef HART_BOOT_SEQ_TIMEOUT_EN
    tcnt_d      = tcnt_q;
    timeout_d   = timeout_q;
    dbg_d       = '0;
`endif
    case (state_q)
      S_IDLE, S_RUN: begin
        if (start_i) begin
          en_d     = hart_en_i;
          sel_d    = (sel_q & ~hart_en_i) | ({NHARTS{mode_i}} & hart_en_i);
          rst_no_d = '0;
          cnt_d    = CW'(RST_HOLD - 1);
          state_d  = S_ASSERT;
`ifdef HART_BOOT_SEQ_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end else if ((state_q == S_RUN) && resync_i) begin
          state_d = S_SYNC;
`ifdef HART_BOOT_SEQ_TIMEOUT_EN
          tcnt_d  = '0;
`endif
        end
      end
      S_ASSERT: begin
        if (cnt_q == '0) begin
          if (en_q == '0) begin
            state_d = S_RUN;
          end else begin
            ptr_d   = first_idx;
            state_d = S_RELEASE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RELEASE: begin
        // cnt_q == 0 marks a release cycle; disabled harts are never visited.
        if (cnt_q == '0) begin
          rst_no_d[ptr_q] = 1'b1;
          if (has_nxt) begin
            ptr_d = nxt_idx;
            cnt_d = CW'(STAGGER - 1);
          end else begin
            state_d = S_RUN;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_SYNC: begin
        if (all_sleep_now) begin
          sel_d    = sel_q | en_q;
          rst_no_d = '0;
          cnt_d    = CW'(RST_HOLD - 1);
          state_d  = S_ASSERT;
        end
`ifdef HART_BOOT_SEQ_TIMEOUT_EN
        else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          dbg_d     = en_q & ~sleep_i;
          timeout_d = 1'b1;
          sel_d     = sel_q | en_q;
          rst_no_d  = '0;
          cnt_d     = CW'(RST_HOLD - 1);
          state_d   = S_ASSERT;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      en_q        <= '0;
      sel_q       <= '0;
      rst_no_q    <= '0;
      all_sleep_q <= 1'b0;
`ifdef HART_BOOT_SEQ_TIMEOUT_EN
      tcnt_q      <= '0;
      timeout_q   <= 1'b0;
      dbg_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      en_q        <= en_d;
      sel_q       <= sel_d;
      rst_no_q    <= rst_no_d;
      all_sleep_q <= all_sleep_d;
`ifdef HART_BOOT_SEQ_TIMEOUT_EN
      tcnt_q      <= tcnt_d;
      timeout_q   <= timeout_d;
      dbg_q       <= dbg_d;
`endif
    end
  end

  always_comb begin
    for (int i = 0; i < NHARTS; i++) begin
      boot_addr_o[i] = sel_q[i] ? WFI_BOOT_ADDR : BASE_BOOT_ADDR;
    end
  end

  assign core_rst_no  = rst_no_q;
  assign hart_ready_o = rst_no_q;
  assign busy_o       = (state_q == S_ASSERT) || (state_q == S_RELEASE) || (state_q == S_SYNC);
  assign all_sleep_o  = all_sleep_q;
`ifdef HART_BOOT_SEQ_TIMEOUT_EN
  assign debug_req_o  = dbg_q;
  assign timeout_o    = timeout_q;
`else
  assign debug_req_o  = '0;
  assign timeout_o    = 1'b0;
`endif

endmodule

// File: tb/tb_hart_boot_sequencer.sv
// Directed bench for hart_boot_sequencer: vector table for boot sequencing, hand sequences for resync/priority/timeout.
module tb_hart_boot_sequencer;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] WFI  = 32'h1000_0200;

  logic            clk = 1'b0;
  logic            rst, start, mode, resync;
  logic [2:0]      hart_en, sleep;
  logic [2:0]      core_rst_no, debug_req, hart_ready;
  logic [2:0][31:0] boot_addr;
  logic            busy, all_sleep, timeout;

  int n_chk  = 0;
  int n_fail = 0;

  hart_boot_sequencer #(
    .NHARTS(3), .BASE_BOOT_ADDR(BASE), .WFI_BOOT_ADDR(WFI),
    .RST_HOLD(4), .STAGGER(2), .TIMEOUT(16)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode),
    .hart_en_i(hart_en), .resync_i(resync), .sleep_i(sleep),
    .core_rst_no(core_rst_no), .boot_addr_o(boot_addr), .debug_req_o(debug_req),
    .hart_ready_o(hart_ready), .busy_o(busy), .all_sleep_o(all_sleep), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst, start, mode;
    logic [2:0] en;
    logic [2:0] exp_rst_no;
    logic       exp_busy;
    logic [2:0] exp_sel;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string name, logic r, logic s, logic m, logic [2:0] en,
                              logic [2:0] er, logic eb, logic [2:0] es);
    vec_t v;
    v.name = name; v.rst = r; v.start = s; v.mode = m; v.en = en;
    v.exp_rst_no = er; v.exp_busy = eb; v.exp_sel = es;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(string name, logic [2:0] er, logic eb, logic eas,
                            logic [2:0] es, logic [2:0] edbg, logic eto);
    chk({name, ".core_rst_no"}, 32'(core_rst_no), 32'(er));
    chk({name, ".hart_ready"}, 32'(hart_ready), 32'(er));
    chk({name, ".busy"}, 32'(busy), 32'(eb));
    chk({name, ".all_sleep"}, 32'(all_sleep), 32'(eas));
    chk({name, ".debug_req"}, 32'(debug_req), 32'(edbg));
    chk({name, ".timeout"}, 32'(timeout), 32'(eto));
    for (int i = 0; i < 3; i++)
      chk($sformatf("%s.boot_addr%0d", name, i), boot_addr[i], es[i] ? WFI : BASE);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    start  = 1'b0;
    resync = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while (busy === 1'b1 && n < 60) begin
      step();
      n++;
    end
    chk({name, ".done_in_budget"}, 32'(busy), 32'd0);
  endtask

  task automatic boot(logic m, logic [2:0] en);
    start = 1'b1; mode = m; hart_en = en;
    step();
    wait_idle("boot");
  endtask

  initial begin
    logic [2:0] rel_exp[9];
    rel_exp = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b011, 3'b011, 3'b111};
    rst = 1'b1; start = 1'b0; mode = 1'b0; resync = 1'b0; hart_en = '0; sleep = '0;

    //   name        rst start mode en      rst_no  busy sel
    add("rst0",      1, 0, 0, 3'b000, 3'b000, 0, 3'b000);
    add("rst1",      1, 0, 0, 3'b000, 3'b000, 0, 3'b000);
    add("rst2",      1, 0, 0, 3'b000, 3'b000, 0, 3'b000);
    add("idle",      0, 0, 0, 3'b000, 3'b000, 0, 3'b000);
    add("b_start",   0, 1, 0, 3'b111, 3'b000, 1, 3'b000);
    add("b_as1",     0, 0, 0, 3'b000, 3'b000, 1, 3'b000);
    add("b_as2",     0, 0, 0, 3'b000, 3'b000, 1, 3'b000);
    add("b_as3",     0, 0, 0, 3'b000, 3'b000, 1, 3'b000);
    add("b_rel0",    0, 0, 0, 3'b000, 3'b000, 1, 3'b000);
    add("b_h0",      0, 0, 0, 3'b000, 3'b001, 1, 3'b000);
    add("b_h0w",     0, 0, 0, 3'b000, 3'b001, 1, 3'b000);
    add("b_h1",      0, 0, 0, 3'b000, 3'b011, 1, 3'b000);
    add("b_h1w",     0, 0, 0, 3'b000, 3'b011, 1, 3'b000);
    add("b_h2",      0, 0, 0, 3'b000, 3'b111, 0, 3'b000);
    add("b_run",     0, 0, 0, 3'b000, 3'b111, 0, 3'b000);
    add("s_start",   0, 1, 1, 3'b101, 3'b000, 1, 3'b101);
    add("s_as1",     0, 0, 0, 3'b000, 3'b000, 1, 3'b101);
    add("s_as2",     0, 0, 0, 3'b000, 3'b000, 1, 3'b101);
    add("s_as3",     0, 0, 0, 3'b000, 3'b000, 1, 3'b101);
    add("s_rel0",    0, 0, 0, 3'b000, 3'b000, 1, 3'b101);
    add("s_h0",      0, 0, 0, 3'b000, 3'b001, 1, 3'b101);
    add("s_h0w",     0, 0, 0, 3'b000, 3'b001, 1, 3'b101);
    add("s_h2",      0, 0, 0, 3'b000, 3'b101, 0, 3'b101);
    add("s_run",     0, 0, 0, 3'b000, 3'b101, 0, 3'b101);
    add("z_start",   0, 1, 0, 3'b000, 3'b000, 1, 3'b101);
    add("z_as1",     0, 0, 0, 3'b000, 3'b000, 1, 3'b101);
    add("z_as2",     0, 0, 0, 3'b000, 3'b000, 1, 3'b101);
    add("z_as3",     0, 0, 0, 3'b000, 3'b000, 1, 3'b101);
    add("z_run",     0, 0, 0, 3'b000, 3'b000, 0, 3'b101);
    add("r_start",   0, 1, 1, 3'b111, 3'b000, 1, 3'b111);
    add("r_as1",     0, 0, 0, 3'b000, 3'b000, 1, 3'b111);
    add("r_reset",   1, 0, 0, 3'b000, 3'b000, 0, 3'b000);

    foreach (vecs[k]) begin
      rst = vecs[k].rst; start = vecs[k].start; mode = vecs[k].mode; hart_en = vecs[k].en;
      step();
      check_outs(vecs[k].name, vecs[k].exp_rst_no, vecs[k].exp_busy, 1'b0,
                 vecs[k].exp_sel, 3'b000, 1'b0);
    end
    rst = 1'b0;

    // Resync: sleep rises 5 cycles after the request, then WFI re-release in order.
    boot(1'b0, 3'b111);
    resync = 1'b1;
    step();
    check_outs("rs_enter", 3'b111, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0);
    for (int k = 1; k < 5; k++) begin
      step();
      check_outs($sformatf("rs_wait%0d", k), 3'b111, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0);
    end
    sleep = 3'b111;
    step();
    check_outs("rs_asleep", 3'b000, 1'b1, 1'b1, 3'b111, 3'b000, 1'b0);
    for (int k = 0; k < 9; k++) begin
      step();
      check_outs($sformatf("rs_rel%0d", k), rel_exp[k], (k != 8), 1'b0, 3'b111, 3'b000, 1'b0);
    end
    sleep = 3'b000;
    step();

    // start and resync together in RUN: start wins, reset asserted immediately.
    start = 1'b1; resync = 1'b1; mode = 1'b0; hart_en = 3'b011;
    step();
    check_outs("pri_start", 3'b000, 1'b1, 1'b0, 3'b100, 3'b000, 1'b0);
    for (int k = 0; k < 4; k++) step();
    step();
    check_outs("pri_h0", 3'b001, 1'b1, 1'b0, 3'b100, 3'b000, 1'b0);
    start = 1'b1; mode = 1'b1; hart_en = 3'b111;
    step();
    check_outs("ign_start", 3'b001, 1'b1, 1'b0, 3'b100, 3'b000, 1'b0);
    step();
    check_outs("ign_h1", 3'b011, 1'b0, 1'b0, 3'b100, 3'b000, 1'b0);

    // Resync with hart 2 never sleeping.
    boot(1'b0, 3'b111);
    sleep = 3'b011;
    resync = 1'b1;
    step();
`ifdef HART_BOOT_SEQ_TIMEOUT_EN
    for (int k = 1; k < 16; k++) begin
      step();
      check_outs($sformatf("to_wait%0d", k), 3'b111, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0);
    end
    step();
    check_outs("to_fire", 3'b000, 1'b1, 1'b0, 3'b111, 3'b100, 1'b1);
    step();
    check_outs("to_sticky", 3'b000, 1'b1, 1'b0, 3'b111, 3'b000, 1'b1);
    wait_idle("to_rerun");
    chk("to_sticky_run", 32'(timeout), 32'd1);
    start = 1'b1; mode = 1'b0; hart_en = 3'b111;
    step();
    chk("to_clear_on_start", 32'(timeout), 32'd0);
    sleep = 3'b000;
    wait_idle("to_final");
`else
    for (int k = 1; k < 21; k++) begin
      step();
      check_outs($sformatf("nto_wait%0d", k), 3'b111, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0);
    end
    sleep = 3'b111;
    step();
    check_outs("nto_asleep", 3'b000, 1'b1, 1'b1, 3'b111, 3'b000, 1'b0);
    sleep = 3'b000;
    wait_idle("nto_final");
    chk("nto_released", 32'(core_rst_no), 32'd7);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
